resp_router: RTL and testbench
==============================

Name: resp_router

Overview:
- Return-path companion to the fixed-priority request arbiter in front of the shared memory port.
- Records, in issue order, which requester port won each accepted request.
- Routes the in-order response stream back to that port with valid/ready handshakes.
- Sits between the shared memory response channel and the per-unit (load/store) response interfaces.

Parameters:
- PORTS, 4: number of requester ports; must match the arbiter.
- DATA_W, 32: response payload width.
- MAX_OUTSTANDING, 8: depth of the outstanding-ID FIFO; must be at least 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- grant_i  input  PORTS  one-hot grant vector from the arbiter.
- req_fire_i  input  1  the granted request was accepted downstream in this cycle (valid & ready).
- req_stall_o  output  1  outstanding FIFO is full; upstream must not fire a request.
- rsp_valid_i  input  1  shared response valid.
- rsp_ready_o  output  1  shared response ready.
- rsp_data_i  input  DATA_W  shared response payload.
- rsp_valid_o  output  PORTS  per-port response valid; at most one bit set.
- rsp_ready_i  input  PORTS  per-port response ready.
- rsp_data_o  output  DATA_W  response payload, broadcast to all ports.
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  number of entries currently stored.
- err_o  output  1  sticky protocol-error flag.

Behaviour:
- FIFO storage:
  - Circular buffer of MAX_OUTSTANDING entries, each $clog2(PORTS) bits (minimum 1).
  - Write pointer, read pointer and count registers.
  - Pointers wrap from MAX_OUTSTANDING-1 to 0; this must be correct for non-power-of-2 depths.
- Push:
  - Condition: req_fire_i && !full.
  - Stored value: index of the lowest set bit of grant_i.
- Pop:
  - Condition: rsp_valid_i && rsp_ready_o.
- Routing (combinational from head entry H):
  - rsp_valid_o[H] = rsp_valid_i && !empty; all other bits are 0.
  - rsp_ready_o = rsp_ready_i[H] && !empty.
  - rsp_data_o = rsp_data_i, unconditionally.
- Latency:
  - Zero-cycle pass-through from response input to port output.
  - An entry pushed in cycle N is first routable in cycle N+1.
- Flow control:
  - req_stall_o = (count == MAX_OUTSTANDING).
  - outstanding_o = count.
- Simultaneous push and pop:
  - The count is unchanged and both pointers advance.
  - When full, a pop frees space in the next cycle only. req_stall_o stays high in the current cycle; there is no combinational ready-through.
- Empty:
  - rsp_ready_o = 0 and rsp_valid_o = 0; the response is held off, not dropped.
- err_o is set on the next edge, and held until reset, when any of these occurs:
  - req_fire_i while full (the push is discarded);
  - req_fire_i with grant_i not exactly one-hot (zero or multiple bits; the push still uses the lowest set bit, or index 0 if grant_i is zero);
  - rsp_valid_i while empty.
- Reset (asynchronous, active-low):
  - Pointers, count and err_o are cleared immediately.
  - Outputs while reset is asserted: req_stall_o=0, rsp_ready_o=0, rsp_valid_o=0, outstanding_o=0, err_o=0.
  - Reset during an outstanding transaction discards all entries; later responses set err_o.
- No clock gating and no internal state machine beyond FIFO control.

Optional Feature:
- Macro: RESP_ROUTER_BYPASS_EN.
- With the macro defined, when the FIFO is empty and req_fire_i is high:
  - the response path routes to the incoming grant index in the same cycle;
  - if the response handshake also completes in that cycle, there is no push and no pop, and count stays 0;
  - in this bypass case, rsp_valid_i while empty does not set err_o.
- Without the macro: no bypass. Minimum fire-to-response latency is 1 cycle, and a same-cycle response is held off and flags err_o.

Test Plan:
- Reset, then single transaction: grant_i=4'b0100 with req_fire_i for 1 cycle; next cycle rsp_valid_i=1, rsp_data_i=32'hCAFE0001, rsp_ready_i=4'b0100 -> rsp_valid_o=4'b0100, rsp_data_o=32'hCAFE0001, rsp_ready_o=1, and outstanding_o goes 0->1->0.
- In-order routing: fire grants to ports 0, 3, 1; return 3 responses with all rsp_ready_i=1 -> rsp_valid_o sequence 0001, 1000, 0010; err_o stays 0.
- Full/backpressure:
  - fire 8 requests (MAX_OUTSTANDING=8) -> req_stall_o=1 and outstanding_o=8;
  - a 9th req_fire_i -> err_o=1 and outstanding_o stays 8;
  - one pop -> req_stall_o=0 on the next cycle.
- Per-port stall: head entry is port 2, rsp_ready_i[2]=0 for 3 cycles -> rsp_ready_o=0 and the entry is held; release -> popped in the cycle ready rises; responses for other ports do not overtake.
- Wrap and simultaneous events: with MAX_OUTSTANDING=5, run 12 transactions with push and pop in the same cycle at count 3 -> count remains 3, pointers wrap through index 4->0, and routing stays correct.
- Errors and reset:
  - rsp_valid_i while empty -> err_o=1 next cycle (not in bypass builds with a same-cycle fire);
  - grant_i=4'b0110 fire -> err_o=1 and the entry routes to port 1;
  - asserting rst_ni=0 mid-stream with 3 entries -> outstanding_o=0 and err_o=0 asynchronously.

Source files
------------

// File: rtl/resp_router.sv
// ---------------------------------------------------------------------------
// resp_router
//   Return-path router for the shared memory port. Each accepted request's
//   winning port index is recorded in issue order in a small circular FIFO.
//   The in-order response stream is then steered back to that port with
//   valid/ready handshakes and zero-cycle pass-through.
//
//   Optional build macro: RESP_ROUTER_BYPASS_EN
//     When defined, a request fired while the FIFO is empty can be answered
//     in the same cycle. The response is routed straight to the incoming
//     grant index, and nothing is stored if the handshake completes.
// ---------------------------------------------------------------------------
module resp_router #(
   parameter int PORTS           = 4,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [PORTS-1:0]                       grant_i,
   input  logic                                   req_fire_i,
   output logic                                   req_stall_o,
   input  logic                                   rsp_valid_i,
   output logic                                   rsp_ready_o,
   input  logic [DATA_W-1:0]                      rsp_data_i,
   output logic [PORTS-1:0]                       rsp_valid_o,
   input  logic [PORTS-1:0]                       rsp_ready_i,
   output logic [DATA_W-1:0]                      rsp_data_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
   output logic                                   err_o
);

   // Port index width (at least one bit, even for a single port)
   localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
   // Pointer width (at least one bit, even for a depth of one)
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   // Count must be able to hold MAX_OUTSTANDING itself
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

   // Outstanding-ID storage and FIFO control state
   logic [IDX_W-1:0] r_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             r_err;

   // Decoded status and routing signals
   logic             w_empty;
   logic             w_full;
   logic [IDX_W-1:0] w_grant_idx;
   logic             w_grant_onehot;
   logic [IDX_W-1:0] w_head_idx;
   logic             w_bypass;
   logic             w_route_en;
   logic [IDX_W-1:0] w_route_idx;
   logic [PORTS-1:0] w_rsp_valid;
   logic             w_sel_ready;
   logic             w_rsp_hs;
   logic             w_push;
   logic             w_pop;
   logic             w_err_fire_full;
   logic             w_err_grant;
   logic             w_err_rsp_empty;
   logic             w_err_evt;

   // Pointer advance with explicit wrap so non-power-of-2 depths work
   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : (p + 1'b1);
   endfunction

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);

   // Lowest set bit of the grant vector; index 0 when no bit is set
   always_comb begin : grant_decode
      w_grant_idx = '0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         if (grant_i[i]) begin
            w_grant_idx = IDX_W'(i);
         end
      end
   end

   // Exactly one grant bit: non-zero and clearing the lowest bit leaves zero
   assign w_grant_onehot = (grant_i != '0) &&
                           ((grant_i & (grant_i - 1'b1)) == '0);

   assign w_head_idx = r_mem[r_rptr];

`ifdef RESP_ROUTER_BYPASS_EN
   // Same-cycle answer to a request fired into an empty FIFO.
   // Gated by reset so outputs stay quiet while reset is held.
   assign w_bypass = w_empty && req_fire_i && rst_ni;
`else
   assign w_bypass = 1'b0;
`endif

   // The response path is live whenever there is a head entry (or a bypass)
   assign w_route_en  = !w_empty || w_bypass;
   assign w_route_idx = w_bypass ? w_grant_idx : w_head_idx;

   // Steer valid to the selected port and pick up that port's ready
   always_comb begin : route_select
      w_rsp_valid = '0;
      w_sel_ready = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (w_route_idx == IDX_W'(i)) begin
            w_rsp_valid[i] = w_route_en && rsp_valid_i;
            w_sel_ready    = rsp_ready_i[i];
         end
      end
   end

   assign w_rsp_hs = rsp_valid_i && rsp_ready_o;

   // A bypassed transaction that completes leaves no trace in the FIFO;
   // a bypassed request whose response is not accepted is stored normally.
   assign w_push = req_fire_i && !w_full && !(w_bypass && w_rsp_hs);
   assign w_pop  = w_rsp_hs && !w_empty;

   // Protocol violations; a response arriving while empty is held off, not dropped
   assign w_err_fire_full = req_fire_i && w_full;
   assign w_err_grant     = req_fire_i && !w_grant_onehot;
   assign w_err_rsp_empty = rsp_valid_i && w_empty && !w_bypass;
   assign w_err_evt       = w_err_fire_full || w_err_grant || w_err_rsp_empty;

   // FIFO pointers, occupancy and sticky error flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= f_ptr_inc(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= f_ptr_inc(r_rptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_err_evt) begin
            r_err <= 1'b1;
         end
      end
   end

   // Entry storage; contents are only meaningful between push and pop
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_grant_idx;
      end
   end

   assign req_stall_o   = w_full;
   assign rsp_ready_o   = w_route_en && w_sel_ready;
   assign rsp_valid_o   = w_rsp_valid;
   assign rsp_data_o    = rsp_data_i;
   assign outstanding_o = r_count;
   assign err_o         = r_err;

endmodule

// File: tb/tb_resp_router.sv
// ---------------------------------------------------------------------------
// tb_resp_router
//   Directed bench for resp_router. Two instances: depth 8 (main tests)
//   and depth 5 (pointer wrap with simultaneous push/pop). Expected
//   responses are queued by the stimulus, and monitors pop and compare
//   them on every completed response handshake.
// ---------------------------------------------------------------------------
module tb_resp_router;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Instance A : depth 8
   logic [3:0]  a_grant = '0;
   logic        a_fire = 1'b0;
   logic        a_stall;
   logic        a_rsp_valid = 1'b0;
   logic        a_rsp_ready_o;
   logic [31:0] a_rsp_data = '0;
   logic [3:0]  a_rsp_valid_o;
   logic [3:0]  a_rsp_ready = '0;
   logic [31:0] a_rsp_data_o;
   logic [3:0]  a_out;
   logic        a_err;

   // Instance B : depth 5
   logic [3:0]  b_grant = '0;
   logic        b_fire = 1'b0;
   logic        b_stall;
   logic        b_rsp_valid = 1'b0;
   logic        b_rsp_ready_o;
   logic [31:0] b_rsp_data = '0;
   logic [3:0]  b_rsp_valid_o;
   logic [3:0]  b_rsp_ready = '0;
   logic [31:0] b_rsp_data_o;
   logic [2:0]  b_out;
   logic        b_err;

   resp_router #(.PORTS(4), .DATA_W(32), .MAX_OUTSTANDING(8)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .grant_i(a_grant), .req_fire_i(a_fire),
      .req_stall_o(a_stall), .rsp_valid_i(a_rsp_valid), .rsp_ready_o(a_rsp_ready_o),
      .rsp_data_i(a_rsp_data), .rsp_valid_o(a_rsp_valid_o), .rsp_ready_i(a_rsp_ready),
      .rsp_data_o(a_rsp_data_o), .outstanding_o(a_out), .err_o(a_err));

   resp_router #(.PORTS(4), .DATA_W(32), .MAX_OUTSTANDING(5)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .grant_i(b_grant), .req_fire_i(b_fire),
      .req_stall_o(b_stall), .rsp_valid_i(b_rsp_valid), .rsp_ready_o(b_rsp_ready_o),
      .rsp_data_i(b_rsp_data), .rsp_valid_o(b_rsp_valid_o), .rsp_ready_i(b_rsp_ready),
      .rsp_data_o(b_rsp_data_o), .outstanding_o(b_out), .err_o(b_err));

   // Expected {port mask, data} per response, in order
   logic [35:0] expq_a[$];
   logic [35:0] expq_b[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: compare on each completed response handshake
   always @(negedge clk) begin
      logic [35:0] e;
      if (rst_n && a_rsp_valid && a_rsp_ready_o) begin
         if (expq_a.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_unexpected_rsp: got valid_o %0h expected no response", a_rsp_valid_o);
         end else begin
            e = expq_a.pop_front();
            chk("a_rsp_valid_o", {28'd0, a_rsp_valid_o}, {28'd0, e[35:32]});
            chk("a_rsp_data_o", {32'd0, a_rsp_data_o}, {32'd0, e[31:0]});
         end
      end
   end

   always @(negedge clk) begin
      logic [35:0] e;
      if (rst_n && b_rsp_valid && b_rsp_ready_o) begin
         if (expq_b.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_unexpected_rsp: got valid_o %0h expected no response", b_rsp_valid_o);
         end else begin
            e = expq_b.pop_front();
            chk("b_rsp_valid_o", {28'd0, b_rsp_valid_o}, {28'd0, e[35:32]});
            chk("b_rsp_data_o", {32'd0, b_rsp_data_o}, {32'd0, e[31:0]});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fire_a(input logic [3:0] g);
      a_grant = g;
      a_fire  = 1'b1;
      step();
      a_fire  = 1'b0;
      a_grant = '0;
   endtask

   task automatic fire_b(input logic [3:0] g);
      b_grant = g;
      b_fire  = 1'b1;
      step();
      b_fire  = 1'b0;
      b_grant = '0;
   endtask

   // Present one response on A and hold it until accepted (bounded)
   task automatic respond(input logic [3:0] mask, input logic [31:0] d, input logic [3:0] rdy);
      bit done = 1'b0;
      expq_a.push_back({mask, d});
      a_rsp_valid = 1'b1;
      a_rsp_data  = d;
      a_rsp_ready = rdy;
      for (int k = 0; k < 16 && !done; k++) begin
         @(negedge clk);
         if (a_rsp_ready_o) done = 1'b1;
         step();
      end
      a_rsp_valid = 1'b0;
      a_rsp_ready = '0;
      chk("respond_handshake", {63'd0, done}, 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   function automatic logic [3:0] mask_of(input int k);
      logic [3:0] one;
      one = 4'b0001;
      return one << ((k * 3 + 1) % 4);
   endfunction

   initial begin
      logic [3:0] m;
      // ---------------- reset state
      step();
      step();
      chk("rst_stall", {63'd0, a_stall}, 64'd0);
      chk("rst_ready", {63'd0, a_rsp_ready_o}, 64'd0);
      chk("rst_valid_o", {60'd0, a_rsp_valid_o}, 64'd0);
      chk("rst_outstanding", {60'd0, a_out}, 64'd0);
      chk("rst_err", {63'd0, a_err}, 64'd0);
      rst_n = 1'b1;
      step();

      // ---------------- single transaction
      fire_a(4'b0100);
      @(negedge clk);
      chk("t1_out_after_fire", {60'd0, a_out}, 64'd1);
      step();
      expq_a.push_back({4'b0100, 32'hCAFE0001});
      a_rsp_valid = 1'b1;
      a_rsp_data  = 32'hCAFE0001;
      a_rsp_ready = 4'b0100;
      @(negedge clk);
      chk("t1_valid_o", {60'd0, a_rsp_valid_o}, 64'h4);
      chk("t1_ready_o", {63'd0, a_rsp_ready_o}, 64'd1);
      chk("t1_data_o", {32'd0, a_rsp_data_o}, 64'hCAFE0001);
      step();
      a_rsp_valid = 1'b0;
      a_rsp_ready = '0;
      @(negedge clk);
      chk("t1_out_after_pop", {60'd0, a_out}, 64'd0);
      chk("t1_err", {63'd0, a_err}, 64'd0);
      step();

      // ---------------- in-order routing
      fire_a(4'b0001);
      fire_a(4'b1000);
      fire_a(4'b0010);
      respond(4'b0001, 32'h0000_1000, 4'hF);
      respond(4'b1000, 32'h0000_1001, 4'hF);
      respond(4'b0010, 32'h0000_1002, 4'hF);
      @(negedge clk);
      chk("t2_err", {63'd0, a_err}, 64'd0);
      chk("t2_out", {60'd0, a_out}, 64'd0);
      step();

      // ---------------- full / backpressure
      for (int i = 0; i < 8; i++) begin
         m = 4'b0001 << (i % 4);
         fire_a(m);
      end
      @(negedge clk);
      chk("t3_stall_full", {63'd0, a_stall}, 64'd1);
      chk("t3_out_full", {60'd0, a_out}, 64'd8);
      chk("t3_err_before", {63'd0, a_err}, 64'd0);
      step();
      fire_a(4'b0001);
      @(negedge clk);
      chk("t3_err_overflow", {63'd0, a_err}, 64'd1);
      chk("t3_out_overflow", {60'd0, a_out}, 64'd8);
      step();
      expq_a.push_back({4'b0001, 32'h0000_2000});
      a_rsp_valid = 1'b1;
      a_rsp_data  = 32'h0000_2000;
      a_rsp_ready = 4'hF;
      @(negedge clk);
      chk("t3_stall_during_pop", {63'd0, a_stall}, 64'd1);
      step();
      a_rsp_valid = 1'b0;
      a_rsp_ready = '0;
      @(negedge clk);
      chk("t3_stall_after_pop", {63'd0, a_stall}, 64'd0);
      chk("t3_out_after_pop", {60'd0, a_out}, 64'd7);
      step();
      for (int i = 1; i < 8; i++) begin
         m = 4'b0001 << (i % 4);
         respond(m, 32'h0000_2000 + i, 4'hF);
      end
      @(negedge clk);
      chk("t3_out_drained", {60'd0, a_out}, 64'd0);
      step();
      do_reset();

      // ---------------- per-port stall, no overtaking
      fire_a(4'b0100);
      fire_a(4'b0001);
      expq_a.push_back({4'b0100, 32'h0000_3000});
      a_rsp_valid = 1'b1;
      a_rsp_data  = 32'h0000_3000;
      a_rsp_ready = 4'b1011;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t4_ready_held", {63'd0, a_rsp_ready_o}, 64'd0);
         chk("t4_valid_head", {60'd0, a_rsp_valid_o}, 64'h4);
         chk("t4_out_held", {60'd0, a_out}, 64'd2);
         step();
      end
      a_rsp_ready = 4'hF;
      @(negedge clk);
      chk("t4_ready_release", {63'd0, a_rsp_ready_o}, 64'd1);
      step();
      a_rsp_valid = 1'b0;
      a_rsp_ready = '0;
      @(negedge clk);
      chk("t4_out_after_release", {60'd0, a_out}, 64'd1);
      step();
      respond(4'b0001, 32'h0000_3001, 4'hF);

      // ---------------- response while empty
      @(negedge clk);
      chk("t5_err_clean", {63'd0, a_err}, 64'd0);
      step();
      a_rsp_valid = 1'b1;
      a_rsp_data  = 32'h0000_4000;
      a_rsp_ready = 4'hF;
      @(negedge clk);
      chk("t5_empty_ready", {63'd0, a_rsp_ready_o}, 64'd0);
      chk("t5_empty_valid_o", {60'd0, a_rsp_valid_o}, 64'd0);
      chk("t5_err_same_cycle", {63'd0, a_err}, 64'd0);
      step();
      a_rsp_valid = 1'b0;
      a_rsp_ready = '0;
      @(negedge clk);
      chk("t5_err_empty_rsp", {63'd0, a_err}, 64'd1);
      step();
      do_reset();

      // ---------------- non-one-hot grant
      fire_a(4'b0110);
      @(negedge clk);
      chk("t6_err_multi_grant", {63'd0, a_err}, 64'd1);
      step();
      respond(4'b0010, 32'h0000_5000, 4'b0010);
      do_reset();

      // ---------------- async reset mid-stream
      fire_a(4'b0110);
      fire_a(4'b0001);
      fire_a(4'b1000);
      @(negedge clk);
      chk("t7_out_before_rst", {60'd0, a_out}, 64'd3);
      chk("t7_err_before_rst", {63'd0, a_err}, 64'd1);
      step();
      #1;
      rst_n = 1'b0;
      #1;
      chk("t7_async_out", {60'd0, a_out}, 64'd0);
      chk("t7_async_err", {63'd0, a_err}, 64'd0);
      chk("t7_async_stall", {63'd0, a_stall}, 64'd0);
      step();
      rst_n = 1'b1;
      step();
      a_rsp_valid = 1'b1;
      a_rsp_data  = 32'h0000_6000;
      a_rsp_ready = 4'hF;
      @(negedge clk);
      chk("t7_late_rsp_ready", {63'd0, a_rsp_ready_o}, 64'd0);
      step();
      a_rsp_valid = 1'b0;
      a_rsp_ready = '0;
      @(negedge clk);
      chk("t7_late_rsp_err", {63'd0, a_err}, 64'd1);
      step();
      do_reset();

      // ---------------- depth 5: wrap with simultaneous push/pop at count 3
      for (int k = 0; k < 3; k++) fire_b(mask_of(k));
      for (int k = 3; k < 12; k++) begin
         b_grant     = mask_of(k);
         b_fire      = 1'b1;
         b_rsp_valid = 1'b1;
         b_rsp_data  = 32'hB000_0000 + (k - 3);
         b_rsp_ready = 4'hF;
         expq_b.push_back({mask_of(k - 3), 32'hB000_0000 + (k - 3)});
         @(negedge clk);
         chk("t8_count_steady", {61'd0, b_out}, 64'd3);
         chk("t8_ready", {63'd0, b_rsp_ready_o}, 64'd1);
         step();
      end
      b_fire  = 1'b0;
      b_grant = '0;
      for (int k = 9; k < 12; k++) begin
         b_rsp_valid = 1'b1;
         b_rsp_data  = 32'hB000_0000 + k;
         b_rsp_ready = 4'hF;
         expq_b.push_back({mask_of(k), 32'hB000_0000 + k});
         @(negedge clk);
         chk("t8_drain_ready", {63'd0, b_rsp_ready_o}, 64'd1);
         step();
      end
      b_rsp_valid = 1'b0;
      b_rsp_ready = '0;
      @(negedge clk);
      chk("t8_out_drained", {61'd0, b_out}, 64'd0);
      chk("t8_err", {63'd0, b_err}, 64'd0);
      chk("t8_stall", {63'd0, b_stall}, 64'd0);

      chk("a_queue_empty", 64'(expq_a.size()), 64'd0);
      chk("b_queue_empty", 64'(expq_b.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
